lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/scc_pkg.sv | 29 ++
 rtl/lsu_agu.sv | 26 ++
 rtl/lsu_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/scc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : scc_pkg                                                     |
// | Brief  : Shared LSU types: FSM state encoding, opcode constant and   |
// |          a sign-extension helper.                                    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package scc_pkg;

   // First-level opcode field value that selects the load/store group
   localparam logic [1:0] OPC_LDST = 2'b10;

   // Width of the ACCESS-cycle watchdog counter
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WB     = 2'd2,
      ST_FAULT  = 2'd3
   } lsu_state_t;

   // Sign-extend a 16-bit immediate to a 32-bit address offset
   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_agu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : lsu_agu                                                     |
// | Brief  : Combinational address generator: base + sext(offset),       |
// |          wrapping modulo 2^32, with optional word-alignment check.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module lsu_agu
   import scc_pkg::*;
#(
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic [31:0] base,
   input  logic [15:0] offset,
   output logic [31:0] addr,
   output logic        misaligned
);

   // Effective address and alignment flag; overflow simply wraps
   always_comb begin
      addr       = base + sext16(offset);
      misaligned = ALIGN_CHECK && (addr[1:0] != 2'b00);
   end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : lsu_ctrl                                                    |
// | Brief  : Single-outstanding load/store controller. Accepts a decoded |
// |          request, drives one data-memory access, writes loads back   |
// |          to the register file and faults on timeout/misalignment.    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module lsu_ctrl
   import scc_pkg::*;
#(
   parameter int TIMEOUT          = 16,
   parameter int ADDR_ALIGN_CHECK = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_dest,
   input  logic [31:0] req_base,
   input  logic [15:0] req_offset,
   input  logic [31:0] req_wdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        w_enable,
   output logic [2:0]  w_addr,
   output logic [31:0] w_data,
   output logic        stall,
   output logic        done,
   output logic        fault,
   input  logic        fault_clr
);

   localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT);

   lsu_state_t       r_state;
   lsu_state_t       state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_addr;
   logic [31:0]      r_wdata;
   logic [31:0]      r_rdata;
   logic             r_store;
   logic [2:0]       r_dest;

   logic [31:0]      agu_addr;
   logic             agu_misaligned;
   logic             accept;
   logic             limit_hit;

   lsu_agu #(
      .ALIGN_CHECK (ADDR_ALIGN_CHECK != 0)
   ) u_agu (
      .base       (req_base),
      .offset     (req_offset),
      .addr       (agu_addr),
      .misaligned (agu_misaligned)
   );

   assign accept    = (r_state == ST_IDLE) && req_valid;
   // Counter holds cycles already spent in ACCESS; this cycle is number r_cnt+1
   assign limit_hit = ((r_cnt + 1'b1) == C_LIMIT);

   // State register; reset drops straight to IDLE so strobes vanish at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= state_nxt;
      end
   end

   // Next-state logic; mem_ready beats the watchdog in the same cycle
   always_comb begin
      state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               state_nxt = agu_misaligned ? ST_FAULT : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (mem_ready) begin
               state_nxt = r_store ? ST_IDLE : ST_WB;
            end else if (limit_hit) begin
               state_nxt = ST_FAULT;
            end
         end
         ST_WB: begin
            state_nxt = ST_IDLE;
         end
         ST_FAULT: begin
            if (fault_clr) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Request capture on accept, watchdog count and load-data capture in ACCESS
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_store <= 1'b0;
         r_dest  <= '0;
      end else if (accept) begin
         r_cnt   <= '0;
         r_addr  <= agu_addr;
         r_wdata <= req_wdata;
         r_store <= req_store;
         r_dest  <= req_dest;
      end else if (r_state == ST_ACCESS) begin
         r_cnt <= r_cnt + 1'b1;
         if (mem_ready && !r_store) begin
            r_rdata <= mem_rdata;
         end
      end
   end

   // Outputs decoded from state; a store retires in its completing ACCESS cycle
   always_comb begin
      req_ready = (r_state == ST_IDLE);
      stall     = (r_state != ST_IDLE);
      mem_addr  = r_addr;
      mem_wdata = r_wdata;
      mem_read  = (r_state == ST_ACCESS) && !r_store;
      mem_write = (r_state == ST_ACCESS) &&  r_store;
      w_enable  = (r_state == ST_WB);
      w_addr    = (r_state == ST_WB) ? r_dest : 3'd0;
      w_data    = r_rdata;
      done      = (r_state == ST_WB) ||
                  ((r_state == ST_ACCESS) && mem_ready && r_store);
      fault     = (r_state == ST_FAULT);
   end

endmodule
`default_nettype wire
